// File: rtl/mprj_wb_guard.sv
// -----------------------------------------------------------------------------
// mprj_wb_guard
// Sits between the management core's user-project Wishbone master port and the
// user project area. Each management-side single transfer is registered and
// forwarded to the user area. The user's ack and read data are returned to the
// management side. A request the user never acks is terminated after
// TIMEOUT_CYCLES cycles with ERR_DATA, so the CPU cannot hang on an unpowered or
// broken user design. While user_en is low every access is fast-failed with
// ERR_DATA and never reaches the user area.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   user_en                 user area usable (sampled in IDLE only)
//   m_*_i / m_ack_o/m_dat_o management-side Wishbone slave port
//   u_*_o / u_ack_i/u_dat_i user-side Wishbone master port
//   timeout_irq             one-cycle pulse per timeout
//   timeout_count           saturating 8-bit timeout counter
//   clr_count               synchronous clear of timeout_count (wins over +1)
//
// Optional feature (macro MPRJ_WB_GUARD_ERR_ADR_EN)
//   timeout_adr             user address of the most recent timed-out request
// -----------------------------------------------------------------------------
module mprj_wb_guard #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        user_en,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        u_cyc_o,
    output logic        u_stb_o,
    output logic        u_we_o,
    output logic [3:0]  u_sel_o,
    output logic [31:0] u_adr_o,
    output logic [31:0] u_dat_o,
    input  logic        u_ack_i,
    input  logic [31:0] u_dat_i,
    output logic        timeout_irq,
    output logic [7:0]  timeout_count,
`ifdef MPRJ_WB_GUARD_ERR_ADR_EN
    output logic [31:0] timeout_adr,
`endif
    input  logic        clr_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Wait-counter value seen in the last cycle the strobe may stay high;
    // the counter starts at 0 in the first strobe cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_ack_q, m_ack_d;
    logic [31:0]       m_dat_q, m_dat_d;
    logic              u_req_q, u_req_d;
    logic              u_we_q, u_we_d;
    logic [3:0]        u_sel_q, u_sel_d;
    logic [31:0]       u_adr_q, u_adr_d;
    logic [31:0]       u_dat_q, u_dat_d;
    logic              irq_q, irq_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              timeout_s;
`ifdef MPRJ_WB_GUARD_ERR_ADR_EN
    logic [31:0]       tadr_q, tadr_d;
`endif

    // State and output registers; reset clears everything, dropping any
    // user-side strobe and suppressing the pending ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            m_ack_q <= 1'b0;
            m_dat_q <= 32'h0000_0000;
            u_req_q <= 1'b0;
            u_we_q  <= 1'b0;
            u_sel_q <= 4'h0;
            u_adr_q <= 32'h0000_0000;
            u_dat_q <= 32'h0000_0000;
            irq_q   <= 1'b0;
            tcnt_q  <= 8'h00;
`ifdef MPRJ_WB_GUARD_ERR_ADR_EN
            tadr_q  <= 32'h0000_0000;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_ack_q <= m_ack_d;
            m_dat_q <= m_dat_d;
            u_req_q <= u_req_d;
            u_we_q  <= u_we_d;
            u_sel_q <= u_sel_d;
            u_adr_q <= u_adr_d;
            u_dat_q <= u_dat_d;
            irq_q   <= irq_d;
            tcnt_q  <= tcnt_d;
`ifdef MPRJ_WB_GUARD_ERR_ADR_EN
            tadr_q  <= tadr_d;
`endif
        end
    end

    // Next-state logic: request acceptance, ack/timeout/abort resolution and
    // the one-cycle management ack.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_ack_d   = 1'b0;
        m_dat_d   = m_dat_q;
        u_req_d   = u_req_q;
        u_we_d    = u_we_q;
        u_sel_d   = u_sel_q;
        u_adr_d   = u_adr_q;
        u_dat_d   = u_dat_q;
        irq_d     = 1'b0;
        timeout_s = 1'b0;
`ifdef MPRJ_WB_GUARD_ERR_ADR_EN
        tadr_d    = tadr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (user_en) begin
                        u_req_d = 1'b1;
                        u_we_d  = m_we_i;
                        u_sel_d = m_sel_i;
                        u_adr_d = m_adr_i;
                        u_dat_d = m_dat_i;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_REQ;
                    end else begin
                        m_dat_d = ERR_DATA;
                        m_ack_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Ack beats timeout beats abort when they coincide.
                if (u_ack_i) begin
                    m_dat_d = u_dat_i;
                    u_req_d = 1'b0;
                    m_ack_d = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_s = 1'b1;
                    m_dat_d   = ERR_DATA;
                    u_req_d   = 1'b0;
                    m_ack_d   = 1'b1;
                    irq_d     = 1'b1;
                    state_d   = ST_DONE;
`ifdef MPRJ_WB_GUARD_ERR_ADR_EN
                    tadr_d    = u_adr_q;
`endif
                end else if (!m_cyc_i) begin
                    u_req_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                u_req_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Clear wins over a simultaneous increment; the count saturates.
        if (clr_count) begin
            tcnt_d = 8'h00;
        end else if (timeout_s && (tcnt_q != 8'hFF)) begin
            tcnt_d = tcnt_q + 8'h01;
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    assign m_ack_o       = m_ack_q;
    assign m_dat_o       = m_dat_q;
    assign u_cyc_o       = u_req_q;
    assign u_stb_o       = u_req_q;
    assign u_we_o        = u_we_q;
    assign u_sel_o       = u_sel_q;
    assign u_adr_o       = u_adr_q;
    assign u_dat_o       = u_dat_q;
    assign timeout_irq   = irq_q;
    assign timeout_count = tcnt_q;
`ifdef MPRJ_WB_GUARD_ERR_ADR_EN
    assign timeout_adr   = tadr_q;
`endif

endmodule
